hps_emif_bringup_seq: RTL and testbench

//  Per-channel EMIF bring-up sequencer for the HPS subsystem top level, for NUM_CH

---
 rtl/hps_emif_pkg.sv | 14 +
 rtl/hps_emif_ch_seq.sv | 120 ++++++++++++
 rtl/hps_emif_bringup_seq.sv | 59 +++++
 tb/tb_hps_emif_bringup_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hps_emif_pkg.sv
// Shared types for the HPS EMIF bring-up sequencer: per-channel state codes and field widths.
package hps_emif_pkg;
  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_READY  = 3'd3,
    ST_RETRY  = 3'd4,
    ST_FAILED = 3'd5
  } ch_state_e;
endpackage

// File: rtl/hps_emif_ch_seq.sv
// One EMIF channel: cal status synchronisers, bring-up FSM, reset-hold counter,
// calibration timer and retry counter.
module hps_emif_ch_seq
  import hps_emif_pkg::*;
#(
  parameter int RST_HOLD_CYC    = 16,
  parameter int CAL_TIMEOUT_CYC = 1048576,
  parameter int RETRY_MAX       = 3,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               hps_osc_clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cal_success,
  input  logic               cal_fail,
  output logic               emif_rst_n,
  output logic               user_rst_n,
  output ch_state_e          state,
  output logic [RETRY_W-1:0] retries
);
  localparam int HOLD_W = $clog2(RST_HOLD_CYC + 1);
  localparam int TMR_W  = $clog2(CAL_TIMEOUT_CYC);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(CAL_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  logic [SYNC_STAGES-1:0] succ_sync, fail_sync;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [TMR_W-1:0]       tmr;
  logic                   s_ok, s_fail;

  assign s_ok   = succ_sync[SYNC_STAGES-1];
  assign s_fail = fail_sync[SYNC_STAGES-1];

  always_ff @(posedge hps_osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      succ_sync <= '0;
      fail_sync <= '0;
    end else begin
      succ_sync <= {succ_sync[SYNC_STAGES-2:0], cal_success};
      fail_sync <= {fail_sync[SYNC_STAGES-2:0], cal_fail};
    end
  end

  always_ff @(posedge hps_osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      emif_rst_n <= 1'b0;
      user_rst_n <= 1'b0;
      hold_cnt   <= '0;
      tmr        <= '0;
      retries    <= '0;
    end else if (!enable) begin
      state      <= ST_IDLE;
      emif_rst_n <= 1'b0;
      user_rst_n <= 1'b0;
      hold_cnt   <= '0;
      tmr        <= '0;
      retries    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_HOLD;
          retries    <= '0;
          hold_cnt   <= '0;
          emif_rst_n <= 1'b0;
          user_rst_n <= 1'b0;
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= ST_WAIT;
            emif_rst_n <= 1'b1;
            tmr        <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        // A fail report outranks a simultaneous success report.
        ST_WAIT: begin
          if (s_fail) begin
            state <= ST_RETRY;
          end else if (s_ok) begin
            state      <= ST_READY;
            user_rst_n <= 1'b1;
          end else if (tmr == TMR_LAST) begin
            state <= ST_RETRY;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_READY: begin
          if (s_fail || !s_ok) begin
            state      <= ST_RETRY;
            user_rst_n <= 1'b0;
          end
        end
        ST_RETRY: begin
          emif_rst_n <= 1'b0;
          user_rst_n <= 1'b0;
          if (retries < RETRY_LIM) begin
            retries  <= retries + RETRY_W'(1);
            hold_cnt <= '0;
            state    <= ST_HOLD;
          end else begin
            state <= ST_FAILED;
          end
        end
        ST_FAILED: begin
          emif_rst_n <= 1'b0;
          user_rst_n <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          emif_rst_n <= 1'b0;
          user_rst_n <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/hps_emif_bringup_seq.sv
// HPS EMIF bring-up sequencer: NUM_CH independent channel sequencers plus
// registered aggregate ready/fail status.
module hps_emif_bringup_seq
  import hps_emif_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int RST_HOLD_CYC    = 16,
  parameter int CAL_TIMEOUT_CYC = 1048576,
  parameter int RETRY_MAX       = 3,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                        hps_osc_clk,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [NUM_CH-1:0]           cal_success,
  input  logic [NUM_CH-1:0]           cal_fail,
  output logic [NUM_CH-1:0]           emif_rst_n,
  output logic [NUM_CH-1:0]           user_rst_n,
  output logic [STATE_W*NUM_CH-1:0]   ch_state,
  output logic [RETRY_W*NUM_CH-1:0]   ch_retries,
  output logic                        all_ready,
  output logic                        fail_any
);
  ch_state_e         st [NUM_CH];
  logic [NUM_CH-1:0] rdy, fld;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hps_emif_ch_seq #(
      .RST_HOLD_CYC    (RST_HOLD_CYC),
      .CAL_TIMEOUT_CYC (CAL_TIMEOUT_CYC),
      .RETRY_MAX       (RETRY_MAX),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .hps_osc_clk (hps_osc_clk),
      .reset_n     (reset_n),
      .enable      (ch_enable[i]),
      .cal_success (cal_success[i]),
      .cal_fail    (cal_fail[i]),
      .emif_rst_n  (emif_rst_n[i]),
      .user_rst_n  (user_rst_n[i]),
      .state       (st[i]),
      .retries     (ch_retries[i*RETRY_W +: RETRY_W])
    );
    assign ch_state[i*STATE_W +: STATE_W] = st[i];
    assign rdy[i] = (st[i] == ST_READY);
    assign fld[i] = (st[i] == ST_FAILED);
  end

  // Disabled channels count as ready so they do not block the AND-reduction.
  always_ff @(posedge hps_osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      all_ready <= 1'b0;
      fail_any  <= 1'b0;
    end else begin
      all_ready <= (|ch_enable) && (&(rdy | ~ch_enable));
      fail_any  <= |(fld & ch_enable);
    end
  end
endmodule

// File: tb/tb_hps_emif_bringup_seq.sv
// Bench for hps_emif_bringup_seq: directed stimulus pushes cycle-stamped expectations
// into a scoreboard that a negedge monitor checks against the DUT outputs.
module tb_hps_emif_bringup_seq;
  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] ch_enable, cal_success, cal_fail;
  logic [NUM_CH-1:0] emif_rst_n, user_rst_n;
  logic [3*NUM_CH-1:0] ch_state;
  logic [4*NUM_CH-1:0] ch_retries;
  logic              all_ready, fail_any;

  hps_emif_bringup_seq #(
    .NUM_CH (NUM_CH), .RST_HOLD_CYC (4), .CAL_TIMEOUT_CYC (64),
    .RETRY_MAX (2), .SYNC_STAGES (2)
  ) dut (
    .hps_osc_clk (clk),
    .reset_n     (reset_n),
    .ch_enable   (ch_enable),
    .cal_success (cal_success),
    .cal_fail    (cal_fail),
    .emif_rst_n  (emif_rst_n),
    .user_rst_n  (user_rst_n),
    .ch_state    (ch_state),
    .ch_retries  (ch_retries),
    .all_ready   (all_ready),
    .fail_any    (fail_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0 emif_rst_n, 1 user_rst_n, 2 ch_state, 3 ch_retries, 4 all_ready, 5 fail_any
  typedef struct { int cyc; int sel; int ch; int val; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, act_v;

  function automatic string nm(input int sel);
    case (sel)
      0: return "emif_rst_n";
      1: return "user_rst_n";
      2: return "ch_state";
      3: return "ch_retries";
      4: return "all_ready";
      default: return "fail_any";
    endcase
  endfunction

  function automatic int getv(input int sel, input int ch);
    case (sel)
      0: return int'(emif_rst_n[ch]);
      1: return int'(user_rst_n[ch]);
      2: return int'(ch_state[ch*3 +: 3]);
      3: return int'(ch_retries[ch*4 +: 4]);
      4: return int'(all_ready);
      default: return int'(fail_any);
    endcase
  endfunction

  task automatic ex(input int c, input int sel, input int ch, input int v);
    exp_t e;
    e.cyc = c; e.sel = sel; e.ch = ch; e.val = v;
    sb.push_back(e);
  endtask

  task automatic ex_reset(input int c);
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int s = 0; s < 4; s++) ex(c, s, ch, 0);
    ex(c, 4, 0, 0);
    ex(c, 5, 0, 0);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: checks every expectation due this cycle; stale entries count as missed.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_chk++;
        act_v = getv(sb[i].sel, sb[i].ch);
        if (act_v != sb[i].val) begin
          n_fail++;
          $display("FAIL %s ch%0d cyc %0d: got %0d expected %0d",
                   nm(sb[i].sel), sb[i].ch, cyc, act_v, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s ch%0d cyc %0d: check missed", nm(sb[i].sel), sb[i].ch, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a, b, r, c, d;
    reset_n = 1'b1; ch_enable = '0; cal_success = '0; cal_fail = '0;
    #2 reset_n = 1'b0;
    ex_reset(2);
    goto(3); reset_n = 1'b1;

    // Test 1: both channels enabled, success at +10 / +20
    t = 5;
    ex(t+4, 0, 0, 0); ex(t+4, 2, 0, 1); ex(t+5, 0, 0, 1); ex(t+5, 2, 1, 2);
    ex(t+12, 1, 0, 0); ex(t+13, 1, 0, 1); ex(t+13, 2, 0, 3);
    ex(t+22, 1, 1, 0); ex(t+23, 1, 1, 1); ex(t+23, 4, 0, 0); ex(t+24, 4, 0, 1);
    goto(t); ch_enable = 2'b11;
    goto(t+10); cal_success[0] = 1'b1;
    goto(t+20); cal_success[1] = 1'b1;

    // Test 4: drop ch0 success in READY, restore during HOLD
    a = t + 30;
    ex(a+2, 1, 0, 1); ex(a+3, 1, 0, 0); ex(a+3, 2, 0, 4); ex(a+3, 4, 0, 1);
    ex(a+4, 4, 0, 0); ex(a+4, 3, 0, 1); ex(a+4, 0, 0, 0); ex(a+7, 0, 0, 0);
    ex(a+8, 0, 0, 1); ex(a+9, 1, 0, 1); ex(a+9, 2, 0, 3); ex(a+10, 4, 0, 1);
    goto(a); cal_success[0] = 1'b0;
    goto(a+5); cal_success[0] = 1'b1;

    // Test 5: disable ch1 while it sits in WAIT
    b = a + 20;
    ex(b+4, 4, 0, 0); ex(b+9, 2, 1, 2); ex(b+10, 3, 1, 1); ex(b+10, 0, 1, 1);
    ex(b+10, 4, 0, 0); ex(b+11, 2, 1, 0); ex(b+11, 0, 1, 0); ex(b+11, 3, 1, 0);
    ex(b+11, 4, 0, 1);
    goto(b); cal_success[1] = 1'b0;
    goto(b+10); ch_enable = 2'b01;

    // Async reset while ch0 is READY
    r = b + 20;
    ex(r-1, 1, 0, 1); ex_reset(r);
    goto(r); reset_n = 1'b0; cal_success = '0; cal_fail = '0; ch_enable = '0;
    goto(r+2); reset_n = 1'b1;

    // Test 2: ch0 never calibrates -> three timeouts -> FAILED
    c = r + 4;
    ex(c+5, 2, 0, 2); ex(c+68, 2, 0, 2); ex(c+69, 2, 0, 4); ex(c+69, 0, 0, 1);
    ex(c+70, 0, 0, 0); ex(c+70, 3, 0, 1); ex(c+73, 0, 0, 0); ex(c+74, 0, 0, 1);
    ex(c+139, 3, 0, 2); ex(c+207, 2, 0, 4); ex(c+207, 0, 0, 1);
    ex(c+208, 2, 0, 5); ex(c+208, 0, 0, 0); ex(c+208, 3, 0, 2); ex(c+208, 5, 0, 0);
    ex(c+209, 5, 0, 1); ex(c+209, 4, 0, 0); ex(c+209, 0, 1, 0);
    ex(c+212, 5, 0, 1); ex(c+213, 2, 0, 0); ex(c+213, 5, 0, 0);
    goto(c); ch_enable = 2'b01;
    goto(c+212); ch_enable = 2'b00;

    // Test 6: reset mid-WAIT, then restart from HOLD with zero retries
    d = c + 216;
    ex(d+9, 2, 0, 2); ex(d+9, 0, 0, 1); ex_reset(d+10);
    ex(d+12, 2, 0, 1); ex(d+12, 3, 0, 0); ex(d+12, 0, 0, 0);
    ex(d+16, 2, 0, 2); ex(d+16, 0, 0, 1);
    goto(d); ch_enable = 2'b01;
    goto(d+10); reset_n = 1'b0;
    goto(d+11); reset_n = 1'b1;

    // Test 3: success and fail together in WAIT -> RETRY, never READY
    ex(d+22, 2, 0, 2); ex(d+23, 2, 0, 4); ex(d+23, 1, 0, 0);
    ex(d+24, 2, 0, 1); ex(d+24, 3, 0, 1); ex(d+28, 2, 0, 2);
    ex(d+29, 2, 0, 4); ex(d+30, 3, 0, 2); ex(d+35, 2, 0, 4);
    ex(d+36, 2, 0, 5); ex(d+36, 1, 0, 0); ex(d+37, 5, 0, 1); ex(d+37, 4, 0, 0);
    goto(d+20); cal_success[0] = 1'b1; cal_fail[0] = 1'b1;

    goto(d+40);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
